// File: rtl/dino_jump_engine.sv
// Dinosaur jump/duck engine: per-frame parabolic jump physics, hitbox export and a two-stage
// sprite-ROM pixel pipeline for the VGA mixer.
module dino_jump_engine #(
  parameter int unsigned SPRITE_W        = 82,
  parameter int unsigned SPRITE_H        = 88,
  parameter int unsigned DUCK_H          = 44,
  parameter int unsigned X_POS           = 80,
  parameter int unsigned GROUND_Y        = 402,
  parameter int unsigned JUMP_FRAMES     = 60,
  parameter int unsigned GRAV_DIV        = 6,
  parameter int unsigned MIN_JUMP_FRAMES = 12
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        fresh,
  input  logic        game_status,
  input  logic        START,
  input  logic        button_jump,
  input  logic        button_duck,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [13:0] rom_addr,
  output logic        rom_bank,
  input  logic        rom_bit,
  output logic        px,
  output logic        jumping,
  output logic        ducking,
  output logic        landed,
  output logic [8:0]  hit_top,
  output logic [8:0]  hit_bottom
);

  localparam logic [8:0]  LP_GY  = 9'(GROUND_Y);
  localparam logic [8:0]  LP_SH  = 9'(SPRITE_H);
  localparam logic [8:0]  LP_DH  = 9'(DUCK_H);
  localparam logic [9:0]  LP_XL  = 10'(X_POS);
  localparam logic [9:0]  LP_XH  = 10'(X_POS + SPRITE_W);
  localparam logic [13:0] LP_W   = 14'(SPRITE_W);
  localparam logic [7:0]  LP_JF  = 8'(JUMP_FRAMES);
  localparam logic [7:0]  LP_JH  = 8'(JUMP_FRAMES / 2);
  localparam logic [7:0]  LP_MIN = 8'(MIN_JUMP_FRAMES);
  localparam logic [15:0] LP_GD  = 16'(GRAV_DIV);

  typedef enum logic [1:0] {StGround, StAir, StDuck} state_e;

  state_e      r_state;
  logic [7:0]  r_t;
  logic        r_fresh_d;
  logic        r_landed;
  logic        r_jumping;
  logic        r_ducking;
  logic [8:0]  r_hit_top;
  logic [8:0]  r_hit_bottom;
  logic [13:0] r_rom_addr;
  logic        r_rom_bank;
  logic        r_in_d;
  logic        r_px;

  logic        w_tick;
  logic [15:0] w_prod;
  logic [15:0] w_quot;
  logic        w_unused_quot;
  logic [8:0]  w_h_next;
  logic [8:0]  w_bot_next;
  logic [8:0]  w_top_stand;
  logic [8:0]  w_top_duck;
  logic        w_release;

  assign w_tick = r_fresh_d & ~fresh;

  // Height lags t by one frame: it is evaluated from the pre-tick t.
  assign w_prod        = {8'd0, r_t} * ({8'd0, LP_JF} - {8'd0, r_t});
  assign w_quot        = w_prod / LP_GD;
  assign w_unused_quot = ^w_quot[15:9];
  assign w_h_next      = (r_state == StAir) ? w_quot[8:0] : 9'd0;
  assign w_bot_next    = LP_GY - w_h_next;
  assign w_top_stand   = w_bot_next - LP_SH;
  assign w_top_duck    = w_bot_next - LP_DH;
  assign w_release     = ~button_jump & (r_t >= LP_MIN) & (r_t < LP_JH);

  always_ff @(posedge clk) begin
    r_landed <= 1'b0;
    if (!RESET_N) begin
      r_fresh_d    <= 1'b1;
      r_state      <= StGround;
      r_t          <= 8'd0;
      r_jumping    <= 1'b0;
      r_ducking    <= 1'b0;
      r_hit_top    <= LP_GY - LP_SH;
      r_hit_bottom <= LP_GY;
    end else begin
      r_fresh_d <= fresh;
      if (w_tick) begin
        if (!game_status) begin
          if (START) begin
            r_state      <= StGround;
            r_t          <= 8'd0;
            r_jumping    <= 1'b0;
            r_ducking    <= 1'b0;
            r_hit_top    <= LP_GY - LP_SH;
            r_hit_bottom <= LP_GY;
          end
        end else begin
          r_hit_bottom <= w_bot_next;
          unique case (r_state)
            StGround: begin
              if (button_jump) begin
                r_state   <= StAir;
                r_t       <= 8'd1;
                r_jumping <= 1'b1;
                r_ducking <= 1'b0;
                r_hit_top <= w_top_stand;
              end else if (button_duck) begin
                r_state   <= StDuck;
                r_jumping <= 1'b0;
                r_ducking <= 1'b1;
                r_hit_top <= w_top_duck;
              end else begin
                r_jumping <= 1'b0;
                r_ducking <= 1'b0;
                r_hit_top <= w_top_stand;
              end
            end
            StDuck: begin
              if (!button_duck) begin
                r_state   <= StGround;
                r_jumping <= 1'b0;
                r_ducking <= 1'b0;
                r_hit_top <= w_top_stand;
              end else if (button_jump) begin
                r_state   <= StAir;
                r_t       <= 8'd1;
                r_jumping <= 1'b1;
                r_ducking <= 1'b0;
                r_hit_top <= w_top_stand;
              end else begin
                r_jumping <= 1'b0;
                r_ducking <= 1'b1;
                r_hit_top <= w_top_duck;
              end
            end
            StAir: begin
              r_hit_top <= w_top_stand;
              r_ducking <= 1'b0;
              if (r_t >= LP_JF) begin
                r_state   <= StGround;
                r_t       <= 8'd0;
                r_landed  <= 1'b1;
                r_jumping <= 1'b0;
              end else if (w_release) begin
                // Mirror onto the descent; the parabola is symmetric so height stays continuous.
                r_t       <= LP_JF - r_t + 8'd1;
                r_jumping <= 1'b1;
              end else begin
                r_t       <= r_t + 8'd1;
                r_jumping <= 1'b1;
              end
            end
            default: begin
              r_state   <= StGround;
              r_t       <= 8'd0;
              r_jumping <= 1'b0;
              r_ducking <= 1'b0;
              r_hit_top <= w_top_stand;
            end
          endcase
        end
      end
    end
  end

  logic        w_in_row;
  logic        w_in_col;
  logic        w_in;
  logic [13:0] w_rel_row;
  logic [13:0] w_rel_col;
  logic [13:0] w_addr;

  assign w_in_row  = (row_addr >= r_hit_top) && (row_addr < r_hit_bottom);
  assign w_in_col  = (col_addr >= LP_XL) && (col_addr < LP_XH);
  assign w_in      = w_in_row & w_in_col;
  assign w_rel_row = {5'd0, row_addr - r_hit_top};
  assign w_rel_col = {4'd0, col_addr - LP_XL};
  assign w_addr    = w_rel_row * LP_W + w_rel_col;

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      r_rom_addr <= 14'd0;
      r_rom_bank <= 1'b0;
      r_in_d     <= 1'b0;
      r_px       <= 1'b0;
    end else begin
      r_rom_addr <= w_in ? w_addr : 14'd0;
      r_rom_bank <= r_ducking;
      r_in_d     <= w_in;
      r_px       <= r_in_d & rom_bit;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign rom_bank   = r_rom_bank;
  assign px         = r_px;
  assign jumping    = r_jumping;
  assign ducking    = r_ducking;
  assign landed     = r_landed;
  assign hit_top    = r_hit_top;
  assign hit_bottom = r_hit_bottom;

endmodule

// File: doc/dino_jump_engine.md
Name: dino_jump_engine

Overview:
- Parametrised successor to the dinosaur jump/draw block.
- Computes the dinosaur's vertical position once per video frame using a parabolic jump, and now supports variable-height jumps (early release) and ducking.
- Drives a registered pixel for the VGA mixer through an external two-bank sprite ROM (bank 0 stand, bank 1 duck).
- Exports the hitbox bounds to the collision logic.

Parameters:
- SPRITE_W, 82, sprite width in pixels
- SPRITE_H, 88, standing sprite height
- DUCK_H, 44, ducking sprite height (bottom-aligned with the ground)
- X_POS, 80, leftmost sprite column
- GROUND_Y, 402, row just below the feet; must be >= SPRITE_H + peak height
- JUMP_FRAMES, 60, full jump duration in frames (even, <= 254)
- GRAV_DIV, 6, parabola divisor
- MIN_JUMP_FRAMES, 12, frames before an early release takes effect

Ports:
- clk  in  1  pixel-domain clock
- RESET_N  in  1  synchronous active-low reset
- fresh  in  1  frame strobe; its falling edge marks a new frame
- game_status  in  1  1 = running, 0 = paused
- START  in  1  restart request while paused
- button_jump  in  1  jump button, level
- button_duck  in  1  duck button, level
- row_addr  in  9  current VGA row
- col_addr  in  10  current VGA column
- rom_addr  out  14  sprite-local address, row*SPRITE_W+col
- rom_bank  out  1  0 stand, 1 duck
- rom_bit  in  1  ROM data, combinational from rom_addr/rom_bank
- px  out  1  dinosaur pixel
- jumping  out  1  airborne flag
- ducking  out  1  duck flag
- landed  out  1  one-clk pulse on touchdown
- hit_top  out  9  top row of the hitbox
- hit_bottom  out  9  bottom row of the hitbox, exclusive

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-low: sampled only on the rising edge of clk.
  - While RESET_N=0, on every clk edge: state=GROUND, t=0, height=0, fresh_d=1, px=0, rom_addr=0, rom_bank=0, landed=0, jumping=0, ducking=0, hit_top=GROUND_Y-SPRITE_H, hit_bottom=GROUND_Y.
- Frame tick:
  - fresh is registered into fresh_d each clk.
  - tick = fresh_d & ~fresh, a one-clk pulse.
  - All state and physics updates happen only on the clk where tick=1.
- Pause:
  - game_status=0: state, t and height are frozen.
  - If START=1 on a tick while paused: state=GROUND, t=0, height=0.
  - px rendering continues while paused.
- State machine (evaluated on tick, game_status=1):
  - GROUND:
    - button_jump=1 -> AIR, t=1. Jump has priority over duck.
    - Else button_duck=1 -> DUCK.
  - DUCK:
    - button_duck=0 -> GROUND.
    - button_jump=1 -> AIR, t=1.
  - AIR, in priority order:
    - t >= JUMP_FRAMES -> GROUND, t=0, landed pulses for one clk on this tick.
    - Else if button_jump=0 and MIN_JUMP_FRAMES <= t < JUMP_FRAMES/2 -> t = JUMP_FRAMES - t + 1. This mirrors to the descent; height stays continuous because the parabola is symmetric.
    - Else t = t+1.
    - button_duck is ignored while in AIR.
- Physics:
  - height = (t*(JUMP_FRAMES-t)) / GRAV_DIV.
  - The product uses a 16-bit intermediate; the division truncates.
  - height is registered on the tick (one-frame latency relative to t).
  - height = 0 in GROUND and DUCK.
- Geometry (registered on tick):
  - cur_h = DUCK_H in DUCK, else SPRITE_H.
  - hit_bottom = GROUND_Y - height.
  - hit_top = hit_bottom - cur_h.
  - jumping = (state==AIR); ducking = (state==DUCK).
- Pixel pipeline (every clk, no tick dependency):
  - Stage 1: in = (hit_top <= row_addr < hit_bottom) && (X_POS <= col_addr < X_POS+SPRITE_W).
    - rom_addr = (row_addr-hit_top)*SPRITE_W + (col_addr-X_POS); forced to 0 when not in.
    - rom_bank = ducking.
    - in_d = in.
  - Stage 2: px = in_d & rom_bit.
  - Total latency from row/col to px is 2 clk; the mixer compensates.
- Boundary cases:
  - Pixels outside the box: px=0.
  - A jump press during the landing tick does not re-trigger on that tick; a new jump starts on the next tick.
  - A geometry change mid-frame takes effect from the next pixel after the tick.

Test Plan:
- Reset, then a full jump: hold RESET_N=0 for 3 clk, expect px=0, hit_top=314, hit_bottom=402. Then hold button_jump with game_status=1 for 61 ticks. Expect height=150 (hit_bottom=252) at t=30, and height=9 at t=1. landed pulses exactly once, on the tick where t reaches 60, and hit_bottom returns to 402.
- Early release: press jump, release it just before the tick on which t=15 is evaluated. Expect t to become 46. height must never jump: 112 at t=15 and 112 at t=45; total air time 31 ticks.
- Release before MIN_JUMP_FRAMES: release at t=5. No mirror until t=12, then t becomes 49.
- Duck: button_duck=1 in GROUND. Expect ducking=1, hit_top=358, rom_bank=1. Pressing jump while ducking gives AIR with hit_top computed from SPRITE_H (88).
- Pause/START: pause at t=20 and expect height frozen over 10 ticks. START on a tick gives GROUND with hit_bottom=402. Resuming does not continue the old jump.
- Pixel pipeline, in GROUND:
  - row=314, col=80, rom_bit=1: expect rom_addr=0 after 1 clk and px=1 after 2 clk.
  - col=162: px=0 and rom_addr=0.
  - row=401, col=161: rom_addr=7215.
